// File: rtl/cello_lut_pkg.sv
// Shared types and constants for the Cello truth-table evaluator.
package cello_lut_pkg;

  localparam logic [7:0] TT_0X61 = 8'h61;

  function automatic int unsigned tt_w(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StLoading,
    StFull
  } cfg_state_e;

endpackage

// File: rtl/cello_lut_stage.sv
// One valid/ready register slice carrying a single result bit.
module cello_lut_stage (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_valid,
  input  logic i_data,
  output logic o_valid,
  output logic o_data
);

  logic r_valid;
  logic r_data;

  // Data is only captured with a valid beat so a drained slot keeps its last value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/cello_lut_seq.sv
// N-input truth-table function with serial reloadable table and a DELAY-deep
// valid/ready pipeline modelling gate-cascade propagation.
module cello_lut_seq
  import cello_lut_pkg::*;
#(
  parameter int unsigned               N_IN     = 3,
  parameter int unsigned               DELAY    = 2,
  parameter logic [tt_w(N_IN)-1:0]     TT_RESET = TT_0X61,
  parameter int unsigned               CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_data,
  input  logic                  cfg_shift,
  input  logic                  cfg_bit,
  input  logic                  cfg_commit,
  output logic                  cfg_err,
  output logic [tt_w(N_IN)-1:0] active_tt,
  output logic [CNT_W-1:0]      done_cnt
);

  localparam int unsigned           TT_W   = tt_w(N_IN);
  localparam int unsigned           BC_W   = $clog2(TT_W + 1);
  localparam logic [BC_W-1:0]       TT_W_C = BC_W'(TT_W);

  cfg_state_e       r_state;
  cfg_state_e       w_state_d;
  logic [TT_W-1:0]  r_shadow;
  logic [TT_W-1:0]  w_shadow_d;
  logic [BC_W-1:0]  r_cnt;
  logic [BC_W-1:0]  w_cnt_d;
  logic [BC_W-1:0]  w_cnt_inc;
  logic [TT_W-1:0]  r_tt;
  logic [TT_W-1:0]  w_tt_d;
  logic             r_err;
  logic             w_err_d;
  logic [CNT_W-1:0] r_done;

  logic [DELAY:0]   w_chain_v;
  logic [DELAY:0]   w_chain_d;
  logic [DELAY-1:0] w_load;

  assign w_cnt_inc = r_cnt + BC_W'(1);

  // Config FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Config FSM: next state; a commit always wins over a same-cycle shift
  always_comb begin
    w_state_d = r_state;
    if (cfg_commit) begin
      w_state_d = StIdle;
    end else if (cfg_shift) begin
      case (r_state)
        StIdle:    w_state_d = (TT_W_C == BC_W'(1)) ? StFull : StLoading;
        StLoading: w_state_d = (w_cnt_inc == TT_W_C) ? StFull : StLoading;
        StFull:    w_state_d = StFull;
        default:   w_state_d = StIdle;
      endcase
    end
  end

  // Config FSM: table datapath updates
  always_comb begin
    w_shadow_d = r_shadow;
    w_cnt_d    = r_cnt;
    w_tt_d     = r_tt;
    w_err_d    = r_err;
    if (cfg_commit) begin
      w_cnt_d = '0;
      if (r_state == StFull) begin
        w_tt_d  = r_shadow;
        w_err_d = 1'b0;
      end else begin
        w_err_d = 1'b1;
      end
    end else if (cfg_shift) begin
      w_shadow_d = {r_shadow[TT_W-2:0], cfg_bit};
      w_cnt_d    = (r_state == StFull) ? TT_W_C : w_cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_cnt    <= '0;
      r_tt     <= TT_RESET;
      r_err    <= 1'b0;
    end else begin
      r_shadow <= w_shadow_d;
      r_cnt    <= w_cnt_d;
      r_tt     <= w_tt_d;
      r_err    <= w_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= '0;
    end else if (out_valid && out_ready) begin
      r_done <= r_done + CNT_W'(1);
    end
  end

  // Lookup at acceptance, so later commits cannot touch in-flight results.
  assign w_chain_v[0] = in_valid;
  assign w_chain_d[0] = r_tt[in_data];

  for (genvar k = 0; k < DELAY; k++) begin : g_stage
    localparam logic [DELAY-1:0] LowMask = DELAY'((64'd1 << k) - 64'd1);

    // Slot k can load unless it and every slot after it are full with the sink stalled.
    assign w_load[k] = out_ready | ~&(w_chain_v[DELAY:1] | LowMask);

    cello_lut_stage u_stage (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_load  (w_load[k]),
      .i_valid (w_chain_v[k]),
      .i_data  (w_chain_d[k]),
      .o_valid (w_chain_v[k+1]),
      .o_data  (w_chain_d[k+1])
    );
  end

  assign in_ready  = w_load[0];
  assign out_valid = w_chain_v[DELAY];
  assign out_data  = w_chain_d[DELAY];
  assign cfg_err   = r_err;
  assign active_tt = r_tt;
  assign done_cnt  = r_done;

endmodule

// File: tb/tb_cello_lut_seq.sv
// Scoreboard bench for cello_lut_seq: driver queues expected bits, monitor checks outputs.
module tb_cello_lut_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  in_data = '0;
  logic        out_ready = 1'b1;
  logic        cfg_shift = 1'b0;
  logic        cfg_bit = 1'b0;
  logic        cfg_commit = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_data;
  logic        cfg_err;
  logic [7:0]  active_tt;
  logic [15:0] done_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int first_acc = -1;
  int first_out = -1;
  bit sb[$];
  bit stall_prev = 1'b0;
  logic stall_data = 1'b0;

  bit exp_def[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  bit exp_par[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  cello_lut_seq #(
    .N_IN     (3),
    .DELAY    (2),
    .TT_RESET (8'h61),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_shift  (cfg_shift),
    .cfg_bit    (cfg_bit),
    .cfg_commit (cfg_commit),
    .cfg_err    (cfg_err),
    .active_tt  (active_tt),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Monitor: pops on every output handshake and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) chk("stall_hold", out_data, stall_data);
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          chk("out_data", out_data, sb.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic send(input logic [2:0] d, input bit e);
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        if (first_acc < 0) first_acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    fail("accept_timeout");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) begin
      fail("drain_timeout");
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_shift = 1'b1;
      cfg_bit   = v[7-i];
      @(posedge clk);
      #1;
    end
    cfg_shift = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(posedge clk);
    #1;
    cfg_commit = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_active_tt", active_tt, 8'h61);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Default 0x61 function, back-to-back
    for (int i = 0; i < 8; i++) send(3'(i), exp_def[i]);
    drain();
    chk("latency", first_out - first_acc, 2);
    chk("done_cnt_8", done_cnt, 8);

    // Short load: rejected, table unchanged
    shift_bits(8'hFF, 5);
    commit();
    chk("short_err", cfg_err, 1);
    chk("short_tt", active_tt, 8'h61);

    // Commit race with a full all-zero load
    shift_bits(8'h00, 8);
    cfg_commit = 1'b1;
    send(3'd0, 1'b1);
    cfg_commit = 1'b0;
    send(3'd0, 1'b0);
    drain();
    chk("race_tt", active_tt, 8'h00);
    chk("race_err_clr", cfg_err, 0);

    // Overshifted load: the last eight bits win
    shift_bits(8'h5A, 8);
    shift_bits(8'h96, 8);
    commit();
    chk("reload_tt", active_tt, 8'h96);
    chk("reload_err", cfg_err, 0);
    for (int i = 0; i < 8; i++) send(3'(i), exp_par[i]);
    drain();
    chk("done_cnt_18", done_cnt, 18);

    // Backpressure: sink stalled for four cycles under continuous input
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(3'(i), exp_par[i]);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_ready_c", in_ready, 0);
        @(negedge clk);
        chk("bp_ready_d", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("done_cnt_24", done_cnt, 24);

    // Reset with two results in flight
    out_ready = 1'b0;
    send(3'd1, 1'b1);
    send(3'd2, 1'b1);
    chk("inflight_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_tt", active_tt, 8'h61);
    chk("mid_rst_done", done_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(3'd5, 1'b1);
    drain();
    chk("post_rst_done", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cello_lut_seq.md
Name: cello_lut_seq

Overview:
- Parametrised, registered successor to the fixed 3-input Cello NOR/NOT logic circuits.
- Evaluates an arbitrary N-input Boolean function stored as a 2^N-bit truth table. The table is reloadable at run time through a serial shadow register with an atomic commit.
- Results pass through a DELAY-stage valid/ready pipeline that models gate-cascade propagation delay.
- Sits between stimulus generators and scoreboards in the circuit-emulation fabric; one instance replaces one hard-wired design (e.g. 0x61).

Parameters:
- N_IN, 3, number of Boolean inputs (1..6); table width TT_W = 2^N_IN.
- DELAY, 2, pipeline depth in cycles (>=1).
- TT_RESET, 8'h61, truth table loaded at reset (TT_W bits).
- CNT_W, 16, width of completed-result counter.

Ports:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, input vector valid.
- in_ready, out, 1, block accepts input vector.
- in_data, in, N_IN, input vector; in_data[N_IN-1] is the MSB of the table index.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts result.
- out_data, out, 1, function value.
- cfg_shift, in, 1, shift cfg_bit into the shadow table.
- cfg_bit, in, 1, serial table bit, MSB (tt[TT_W-1]) first.
- cfg_commit, in, 1, copy shadow to active table.
- cfg_err, out, 1, sticky: commit attempted with bit count != TT_W.
- active_tt, out, TT_W, current active table.
- done_cnt, out, CNT_W, count of completed output handshakes; wraps.

Behaviour:
- Reset (async, on rst high):
  - active_tt=TT_RESET, shadow=0, bit count=0, cfg_err=0, done_cnt=0.
  - All stage valids=0, out_valid=0, out_data=0.
  - in_ready=1 once rst is low.
- Evaluation:
  - On in_valid&&in_ready, stage0 loads {valid=1, data=active_tt[in_data]}.
  - The table lookup happens at acceptance. Later commits never alter in-flight results.
- Pipeline:
  - Stage k advances when stage k+1 is empty or advancing. The last stage advances on out_ready.
  - in_ready = !stage0.valid || stage0 advancing. It is combinational from out_ready through the chain.
  - out_valid/out_data are driven by stage DELAY-1.
  - Latency is DELAY cycles, accept to out_valid, with out_ready held high. Throughput is 1/cycle.
  - With out_ready low, up to DELAY results are held. Holding registers keep their data and order is preserved; nothing is dropped or duplicated.
  - out_data must hold stable while out_valid&&!out_ready.
- done_cnt increments on each out_valid&&out_ready and wraps from 2^CNT_W-1 to 0.
- Config FSM, states IDLE/LOADING/FULL:
  - IDLE: count=0. cfg_shift moves to LOADING with count=1.
  - LOADING: each cfg_shift gives shadow <= {shadow[TT_W-2:0], cfg_bit} and count+1. Reaching TT_W moves to FULL.
  - FULL: further shifts keep shifting (last TT_W bits win); count saturates at TT_W.
  - cfg_commit in FULL: active_tt <= shadow, cfg_err <= 0, go to IDLE.
  - cfg_commit in IDLE/LOADING: active_tt unchanged, cfg_err <= 1, go to IDLE (count=0).
  - cfg_commit and cfg_shift in the same cycle: commit wins and the shift is discarded.
- New active_tt is visible to inputs accepted from the cycle after the commit. An input accepted in the commit cycle uses the old table.
- Reset mid-stream flushes the pipeline and reverts the table to TT_RESET. Results lost this way are not counted.

Decomposition:
- Package cello_lut_pkg holds:
  - TT_W as a function of N_IN.
  - Default table constant TT_0X61 = 8'h61.
  - Config FSM state enum (IDLE, LOADING, FULL).
- Sub-module cello_lut_stage: one valid/ready register slice (valid + 1-bit data), instantiated DELAY times by a generate loop.

Test Plan:
- Default function: after reset, feed in_data 0..7 back-to-back with out_ready=1. out_data sequence must be 1,0,0,0,0,1,1,0, first out_valid 2 cycles after first accept, done_cnt=8.
- Reload: shift 1,0,0,1,0,1,1,0 (0x96), commit, then feed 0..7. active_tt=8'h96, outputs equal 3-input parity, cfg_err=0.
- Short load: shift 5 bits, commit. cfg_err=1 and active_tt stays 8'h61. A following full 8-bit load plus commit clears cfg_err.
- Backpressure: continuous in_valid, out_ready low for 4 cycles. in_ready drops after 2 accepts, no results are lost, order is preserved, and out_data is stable while stalled.
- Commit race: accept in_data=3'b000 in the same cycle as committing 0x00. That result is 1 (old table); an input accepted the next cycle yields 0.
- Reset mid-stream: assert rst with 2 results in flight. out_valid goes to 0 immediately, active_tt=8'h61, done_cnt=0.
